// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS32 front-end constants, opcodes and fetch FSM state type.
package mips_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_MISALIGN = 2'b01;
    localparam logic [1:0] FC_BUS      = 2'b10;
    localparam logic [1:0] FC_TIMEOUT  = 2'b11;
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} fetch_state_e;
endpackage

// File: rtl/ifu_timeout_ctr.sv
// ifu_timeout_ctr: clear/enable counter whose terminal count flags the last
// FETCH cycle allowed before a missing acknowledge becomes a fault.
module ifu_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    localparam int W = $clog2(TIMEOUT + 1);
    logic [W-1:0] cnt_q;
    assign tc_o = cnt_q == W'(TIMEOUT - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else if (clr_i) cnt_q <= '0;
        else if (en_i) cnt_q <= cnt_q + 1'b1;
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner and handshaked instruction fetch for the single-cycle core,
// producing one commit strobe per instruction and a sticky fault on bus/alignment/timeout errors.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] next_pc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    output logic [31:0] pc,
    output logic [31:0] instrn,
    output logic [5:0]  instrn_opcode,
    output logic [31:0] address_plus_4,
    output logic        instr_valid,
    output logic [31:0] instr_count,
    output logic        fault,
    output logic [1:0]  fault_code
);
    fetch_state_e state_q, state_d;
    logic [31:0] pc_q, pc_d, instrn_q, instrn_d, count_q, count_d;
    logic [1:0]  code_q, code_d;
    logic        tmo_tc;
    // The timer only runs while a request is outstanding and unanswered.
    ifu_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (state_q != FETCH || imem_ack),
        .en_i  (state_q == FETCH && !imem_ack),
        .tc_o  (tmo_tc)
    );
    assign imem_req       = state_q == FETCH;
    assign imem_addr      = pc_q;
    assign pc             = pc_q;
    assign instrn         = instrn_q;
    assign instrn_opcode  = instrn_q[31:26];
    assign address_plus_4 = pc_q + 32'd4;
    assign instr_valid    = state_q == EXEC && !stall;
    assign instr_count    = count_q;
    assign fault          = state_q == HALT;
    assign fault_code     = code_q;
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instrn_d = instrn_q;
        count_d  = count_q;
        code_d   = code_q;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (imem_ack && imem_err) begin
                    state_d = HALT;
                    code_d  = FC_BUS;
                end else if (imem_ack) begin
                    state_d  = EXEC;
                    instrn_d = imem_rdata;
                end else if (tmo_tc) begin
                    state_d = HALT;
                    code_d  = FC_TIMEOUT;
                end
            end
            EXEC: begin
                if (!stall) begin
                    count_d = count_q + 32'd1;
                    state_d = next_pc[1:0] != 2'b00 ? HALT : FETCH;
                    code_d  = next_pc[1:0] != 2'b00 ? FC_MISALIGN : code_q;
                    pc_d    = next_pc[1:0] != 2'b00 ? pc_q : next_pc;
                end
            end
            HALT: state_d = HALT;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            instrn_q <= NOP;
            count_q  <= '0;
            code_q   <= FC_NONE;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instrn_q <= instrn_d;
            count_q  <= count_d;
            code_q   <= code_d;
        end
    end
endmodule
